// File: rtl/inert_seq_mc.sv
// inert_seq_mc: power-up wait, sensor init-table writes, then NUM_CH x 16-bit reads per INT, published atomically with vld.
// One SPI transaction in flight, paced by done; INT is level-sensitive and not queued. `INT_TMO_EN adds an IDLE watchdog (tmo).
module inert_seq_mc #(
  parameter int                     NUM_CH   = 4,
  parameter logic [NUM_CH*8-1:0]    CH_ADDR  = {8'h2C, 8'h2A, 8'h26, 8'h24},
  parameter int                     NUM_INIT = 4,
  parameter logic [NUM_INIT*16-1:0] INIT_TBL = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
  parameter int                     PWRUP_W  = 16
`ifdef INT_TMO_EN
  , parameter int                   TMO_W    = 20
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reinit,
  input  logic                   INT,
  output logic                   wrt,
  output logic [15:0]            cmd,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  output logic [NUM_CH*16-1:0]   ch_data,
  output logic                   vld,
  output logic                   busy,
  output logic                   ovr,
  output logic                   init_done
`ifdef INT_TMO_EN
  , output logic                 tmo
`endif
);

  typedef enum logic [2:0] {PWRUP, INIT_WR, INIT_WT, IDLE, RD_WR, RD_WT} state_t;

  localparam int         NB         = 2 * NUM_CH;
  localparam logic [3:0] LAST_INIT  = 4'(NUM_INIT - 1);
  localparam logic [3:0] LAST_BYTE  = 4'(NB - 1);

  state_t                    state_q, state_d;
  logic [PWRUP_W-1:0]        timer_q, timer_d;
  logic [3:0]                idx_q, idx_d;
  logic [(NB-1)*8-1:0]       shadow_q, shadow_d;
  logic [NUM_CH*16-1:0]      ch_data_q, ch_data_d;
  logic                      vld_q, vld_d;
  logic                      ovr_q, ovr_d;
  logic                      init_done_q, init_done_d;
  logic                      int_s1_q, int_ff_q, int_dly_q, int_rise;
  logic [6:0]                rd_addr;
  logic [15:0]               init_cmd, rd_cmd;
  logic                      unused_rd_hi;
`ifdef INT_TMO_EN
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
`endif

  assign unused_rd_hi = ^rd_data[15:8];
  assign int_rise     = int_ff_q & ~int_dly_q;

  // Channel low byte at CH_ADDR, high byte at +1; bit 7 of the address is replaced by the read flag.
  assign rd_addr  = CH_ADDR[{idx_q[3:1], 3'b000} +: 7] + {6'd0, idx_q[0]};
  assign rd_cmd   = {1'b1, rd_addr, 8'h00};
  assign init_cmd = INIT_TBL[{idx_q, 4'b0000} +: 16];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    ch_data_d   = ch_data_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    ovr_d       = int_rise && ((state_q == RD_WR) || (state_q == RD_WT));
    wrt         = 1'b0;
    cmd         = 16'h0000;
`ifdef INT_TMO_EN
    tmo         = 1'b0;
    tmo_cnt_d   = '0;
`endif
    case (state_q)
      PWRUP: begin
        if (&timer_q) begin
          state_d = INIT_WR;
          timer_d = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      INIT_WR: begin
        wrt     = 1'b1;
        cmd     = init_cmd;
        state_d = INIT_WT;
      end
      INIT_WT: begin
        cmd = init_cmd;
        if (done) begin
          if (idx_q == LAST_INIT) begin
            state_d     = IDLE;
            idx_d       = '0;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = INIT_WR;
          end
        end
      end
      IDLE: begin
        if (int_ff_q) begin
          state_d = RD_WR;
          idx_d   = '0;
`ifdef INT_TMO_EN
        end else if (&tmo_cnt_q) begin
          tmo         = 1'b1;
          state_d     = INIT_WR;
          idx_d       = '0;
          init_done_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      RD_WR: begin
        wrt     = 1'b1;
        cmd     = rd_cmd;
        state_d = RD_WT;
      end
      RD_WT: begin
        cmd = rd_cmd;
        if (done) begin
          if (idx_q == LAST_BYTE) begin
            ch_data_d = {rd_data[7:0], shadow_q};
            vld_d     = 1'b1;
            idx_d     = '0;
            state_d   = IDLE;
          end else begin
            shadow_d[{idx_q, 3'b000} +: 8] = rd_data[7:0];
            idx_d   = idx_q + 1'b1;
            state_d = RD_WR;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    // reinit overrides whatever the state decided this cycle, including a concurrent done.
    if (reinit) begin
      state_d     = PWRUP;
      timer_d     = '0;
      idx_d       = '0;
      init_done_d = 1'b0;
      shadow_d    = shadow_q;
      ch_data_d   = ch_data_q;
      vld_d       = 1'b0;
`ifdef INT_TMO_EN
      tmo         = 1'b0;
      tmo_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      timer_q     <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      ch_data_q   <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
      init_done_q <= 1'b0;
      int_s1_q    <= 1'b0;
      int_ff_q    <= 1'b0;
      int_dly_q   <= 1'b0;
`ifdef INT_TMO_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      ch_data_q   <= ch_data_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
      init_done_q <= init_done_d;
      int_s1_q    <= INT;
      int_ff_q    <= int_s1_q;
      int_dly_q   <= int_ff_q;
`ifdef INT_TMO_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign ch_data   = ch_data_q;
  assign vld       = vld_q;
  assign ovr       = ovr_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inert_seq_mc.sv
// Directed bench for inert_seq_mc: expected SPI commands and samples are queued up front and consumed as the DUT emits them.
module tb_inert_seq_mc;
  localparam int NUM_CH  = 4;
  localparam int PWRUP_W = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld, busy, ovr, init_done;
  logic [15:0] cmd;
  logic [63:0] ch_data;
`ifdef INT_TMO_EN
  logic        tmo;
`endif

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int ovr_cnt = 0;
  logic [15:0] exp_cmd_q[$];
  logic [63:0] exp_smp_q[$];
  logic [63:0] last_smp = 64'h0;
  logic [63:0] exp_s;

  logic [15:0] init_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_cmds   [8] = '{16'hA400, 16'hA500, 16'hA600, 16'hA700,
                                 16'hAA00, 16'hAB00, 16'hAC00, 16'hAD00};

  always #5 clk = ~clk;

  inert_seq_mc #(
    .NUM_CH(NUM_CH), .CH_ADDR({8'h2C, 8'h2A, 8'h26, 8'h24}), .NUM_INIT(4),
    .INIT_TBL({16'h1460, 16'h1150, 16'h1053, 16'h0D02}), .PWRUP_W(PWRUP_W)
`ifdef INT_TMO_EN
    , .TMO_W(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .INT(INT),
    .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .ch_data(ch_data), .vld(vld), .busy(busy), .ovr(ovr), .init_done(init_done)
`ifdef INT_TMO_EN
    , .tmo(tmo)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outside a vld cycle ch_data must still hold the last published sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vld) begin
        vld_cnt++;
        if (exp_smp_q.size() == 0) begin
          chk("unexpected_vld", vld, 1'b0);
        end else begin
          exp_s = exp_smp_q.pop_front();
          chk("sample", ch_data, exp_s);
          last_smp = exp_s;
        end
      end else begin
        chk("ch_data_hold", ch_data, last_smp);
      end
      if (ovr) ovr_cnt++;
    end
  end

  // Acts as the SPI master for one transaction: waits for wrt, checks cmd, answers with done.
  task automatic serve(input logic [7:0] b, input logic rei);
    int n = 0;
    logic [15:0] e;
    while (!wrt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wrt_seen", wrt, 1'b1);
    e = 16'hxxxx;
    if (exp_cmd_q.size() > 0) e = exp_cmd_q.pop_front();
    chk("cmd", cmd, e);
    @(negedge clk);
    chk("wrt_one_cycle", wrt, 1'b0);
    chk("cmd_hold", cmd, e);
    @(negedge clk);
    done = 1'b1;
    rd_data = {8'hEE, b};
    reinit = rei;
    @(negedge clk);
    done = 1'b0;
    reinit = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic wait_pwrup(input string tag);
    int n = 0;
    while (!wrt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 64'(1 << PWRUP_W));
  endtask

  task automatic run_init();
    for (int i = 0; i < 4; i++) exp_cmd_q.push_back(init_cmds[i]);
    for (int i = 0; i < 4; i++) begin
      chk("init_done_pre", init_done, 1'b0);
      serve(8'h00, 1'b0);
    end
    chk("init_done_post", init_done, 1'b1);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic idle_wait(input int cyc);
    for (int i = 0; i < cyc; i++) @(negedge clk);
  endtask

  initial begin
    idle_wait(3);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_vld", vld, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ch_data", ch_data, 64'h0);
    rst_n = 1'b1;

    wait_pwrup("pwrup_cycles");
    run_init();

    // Plain sample.
    for (int i = 0; i < 8; i++) exp_cmd_q.push_back(rd_cmds[i]);
    exp_smp_q.push_back(64'h1817_1615_1413_1211);
    INT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(8'h11 + 8'(i), 1'b0);
      if (i == 0) INT = 1'b0;
    end
    idle_wait(6);
    chk("s1_vld_cnt", vld_cnt, 1);
    chk("s1_ovr_cnt", ovr_cnt, 0);
    chk("s1_busy", busy, 1'b0);

    // Second INT edge mid-read: overrun flagged, sample still completes.
    ovr_cnt = 0;
    for (int i = 0; i < 8; i++) exp_cmd_q.push_back(rd_cmds[i]);
    exp_smp_q.push_back(64'h2827_2625_2423_2221);
    INT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(8'h21 + 8'(i), 1'b0);
      if (i == 0) INT = 1'b0;
      if (i == 2) INT = 1'b1;
      if (i == 3) INT = 1'b0;
    end
    idle_wait(6);
    chk("s2_ovr_cnt", ovr_cnt, 1);
    chk("s2_vld_cnt", vld_cnt, 2);
    chk("s2_busy", busy, 1'b0);

    // reinit coincident with the 5th done.
    for (int i = 0; i < 5; i++) exp_cmd_q.push_back(rd_cmds[i]);
    INT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(8'h41 + 8'(i), (i == 4));
      if (i == 0) INT = 1'b0;
    end
    chk("ri_busy", busy, 1'b1);
    chk("ri_init_done", init_done, 1'b0);
    chk("ri_wrt", wrt, 1'b0);
    chk("ri_cmd", cmd, 16'h0000);
    wait_pwrup("reinit_pwrup_cycles");
    run_init();
    chk("ri_vld_cnt", vld_cnt, 2);

    // Sample after re-init starts again from byte 0.
    for (int i = 0; i < 8; i++) exp_cmd_q.push_back(rd_cmds[i]);
    exp_smp_q.push_back(64'h3837_3635_3433_3231);
    INT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(8'h31 + 8'(i), 1'b0);
      if (i == 0) INT = 1'b0;
    end
`ifdef INT_TMO_EN
    begin
      int n = 0;
      while (!tmo && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_delay", n, 255);
      @(negedge clk);
      chk("tmo_wrt", wrt, 1'b1);
      chk("tmo_cmd", cmd, 16'h0D02);
      chk("tmo_init_done", init_done, 1'b0);
    end
`else
    idle_wait(6);
    chk("end_busy", busy, 1'b0);
`endif
    chk("end_vld_cnt", vld_cnt, 3);
    chk("end_cmd_q_empty", exp_cmd_q.size(), 0);
    chk("end_smp_q_empty", exp_smp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inert_seq_mc.md
Name: inert_seq_mc

Overview:
Parametrised successor to the single-sensor inertial SPI front end. After a power-up wait it writes a programmable table of configuration commands to the sensor. On each synchronised sensor INT it then reads NUM_CH 16-bit channels (low byte then high byte), and the full sample is published atomically with a one-cycle vld. It sits between an external SPI master (wrt/cmd/done/rd_data handshake) and downstream integrators, and adds overrun detection and a soft re-init.

Parameters:
NUM_CH, 4, number of 16-bit channels read per sample (1..8).
CH_ADDR, {8'h2C,8'h2A,8'h26,8'h24}, packed NUM_CH x 8; low-byte register address per channel, ch0 in LSBs; high byte is at address+1.
NUM_INIT, 4, number of configuration writes (1..8).
INIT_TBL, {16'h1460,16'h1150,16'h1053,16'h0D02}, packed NUM_INIT x 16; entry 0 in LSBs, sent in index order.
PWRUP_W, 16, power-up timer width; init starts when the timer reaches all-ones.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reinit  in  1  one-cycle pulse; restart power-up wait and init sequence
INT  in  1  sensor data-ready, asynchronous; double-flopped internally
wrt  out  1  one-cycle SPI transaction start
cmd  out  16  SPI command word
done  in  1  one-cycle SPI transaction complete
rd_data  in  16  SPI read data; only [7:0] used
ch_data  out  NUM_CH*16  sample; channel c occupies bits [16c+15:16c]
vld  out  1  one-cycle pulse; ch_data updated the same cycle
busy  out  1  high whenever state is not IDLE
ovr  out  1  one-cycle pulse; INT rising edge seen while a read is in progress
init_done  out  1  level; high once the init table is complete

Behaviour:
- Reset values: wrt=0, cmd=0, ch_data=0, vld=0, ovr=0, init_done=0, busy=1, state=PWRUP, timer=0, idx=0.
- Clocking: all flops are posedge clk, with asynchronous clear on negedge rst_n.
- INT is synchronised through two flops (INT_ff). A rising edge is INT_ff & ~INT_ff_d.
- States: PWRUP, INIT_WR, INIT_WT, IDLE, RD_WR, RD_WT.
- PWRUP: timer increments. When timer is all-ones -> INIT_WR, with timer cleared and idx cleared.
- INIT_WR: wrt=1 for exactly one cycle; cmd=INIT_TBL[idx]. Next state is INIT_WT.
- INIT_WT: cmd is held stable.
  - On done with idx=NUM_INIT-1: go to IDLE, idx=0, init_done<=1.
  - On any other done: idx+1, go to INIT_WR.
- IDLE: if INT_ff=1 -> RD_WR with idx=0. INT is level-sensitive, so a still-high INT starts the next sample immediately after vld.
- RD_WR: wrt=1 for one cycle.
  - cmd = {1'b1, addr[6:0], 8'h00}.
  - addr = CH_ADDR[idx>>1] + idx[0].
  - Next state is RD_WT.
- RD_WT: on done, rd_data[7:0] is written into shadow byte idx.
  - If idx<2*NUM_CH-1: idx+1, go to RD_WR.
  - On the last byte: ch_data <= {rd_data[7:0], shadow[all lower bytes]}, vld<=1, idx=0, go to IDLE.
  - ch_data never shows a partially updated sample.
- cmd holds its value through the *_WT states. In PWRUP and IDLE, cmd=0.
- idx wraps only by explicit clear; it is never allowed to exceed 2*NUM_CH-1.
- ovr: pulses when an INT rising edge occurs in RD_WR or RD_WT. The sample in progress continues; the extra INT is not queued.
- reinit takes priority over every transition in every state: go to PWRUP; timer, idx and init_done are cleared.
  - ch_data retains its last value.
  - A done arriving the cycle after reinit is ignored.
- done outside the *_WT states is ignored.
- done and reinit in the same cycle: reinit wins and no byte is stored.
- Asynchronous reset mid-transaction returns to PWRUP immediately; wrt deasserts at once.

Optional Feature:
INT_TMO_EN. Adds an output tmo (1 bit) and a parameter TMO_W (default 20).
- With the macro: a counter runs in IDLE and clears on leaving IDLE.
  - When the counter reaches all-ones, tmo pulses for one cycle, state goes to INIT_WR (sensor re-configuration, no power-up wait) and init_done is cleared.
- Without the macro: no tmo port, no counter, and IDLE waits indefinitely.

Test Plan:
- Reset, then run for 2^16 cycles -> first wrt at timer all-ones. cmd sequence is 0D02, 1053, 1150, 1460, each wrt spaced by a done. init_done goes high after the 4th done.
- INT high with SPI model returning bytes 0x11..0x18 -> cmds A400, A500, A600, A700, AA00, AB00, AC00, AD00. A single vld follows with ch_data = 64'h1817_1615_1413_1211.
- Check ch_data on every cycle during a read -> it stays at the previous sample until the vld cycle.
- INT pulses again after the 3rd byte -> ovr pulses once, vld still occurs, and no second read starts unless INT is still high.
- reinit asserted in the same cycle as the 5th read done -> state goes to PWRUP, no vld, ch_data unchanged, and the full init sequence replays.
- INT_TMO_EN with TMO_W=8 and INT held low after init -> tmo pulses 255 cycles after entering IDLE, followed by wrt with cmd=0D02.
